// File: rtl/lsm_sequencer.sv
// lsm_sequencer: micro-sequencer for LDM/STM block transfers (one register per memory beat).
// Optional macro LSM_PC_LOAD_EN adds pc_loaded, a DONE-cycle pulse for loads whose list includes r15.
module lsm_sequencer #(
  parameter int WORD_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] IR,
  input  logic        mem_ready,
  output logic        busy,
  output logic [3:0]  LSM_RD,
  output logic        LSM_RD_MUX,
  output logic        LATCH_REG,
  output logic        REG_GATE_C,
  output logic        MEM_RD,
  output logic        MEM_WR,
  output logic [31:0] ADDR_OFFSET,
  output logic        WB_EN,
  output logic [31:0] WB_OFFSET,
`ifdef LSM_PC_LOAD_EN
  output logic        pc_loaded,
`endif
  output logic        done
);

  typedef enum logic [1:0] {IDLE, XFER, WB, DONE} state_t;

  localparam logic [31:0] STEP = 32'(WORD_BYTES);

  state_t      state_reg, state_next;
  logic [15:0] list_reg, list_next;
  logic [3:0]  rn_reg, rn_next;
  logic        load_reg, load_next;
  logic        wb_reg, wb_next;
  logic        up_reg, up_next;
  logic        pc_reg, pc_next;
  logic [31:0] offset_reg, offset_next;
  logic [31:0] total_reg, total_next;

  logic [4:0]  pop_count;
  logic [31:0] n_bytes;
  logic [15:0] low_onehot;
  logic [3:0]  low_idx;
  logic        last_beat;

  always_comb begin
    pop_count = '0;
    for (int b = 0; b < 16; b++) begin
      pop_count = pop_count + {4'd0, IR[b]};
    end
  end

  assign n_bytes = STEP * {27'd0, pop_count};

  // Isolate the lowest remaining register, then encode it one index bit at a time.
  assign low_onehot = list_reg & (~list_reg + 16'd1);
  assign last_beat  = (list_reg & (list_reg - 16'd1)) == 16'd0;

  for (genvar gi = 0; gi < 4; gi++) begin : g_enc
    logic [15:0] sel_mask;
    always_comb begin
      sel_mask = '0;
      for (int b = 0; b < 16; b++) begin
        sel_mask[b] = b[gi];
      end
    end
    assign low_idx[gi] = |(low_onehot & sel_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      list_reg   <= '0;
      rn_reg     <= '0;
      load_reg   <= 1'b0;
      wb_reg     <= 1'b0;
      up_reg     <= 1'b0;
      pc_reg     <= 1'b0;
      offset_reg <= '0;
      total_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      list_reg   <= list_next;
      rn_reg     <= rn_next;
      load_reg   <= load_next;
      wb_reg     <= wb_next;
      up_reg     <= up_next;
      pc_reg     <= pc_next;
      offset_reg <= offset_next;
      total_reg  <= total_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    list_next   = list_reg;
    rn_next     = rn_reg;
    load_next   = load_reg;
    wb_next     = wb_reg;
    up_next     = up_reg;
    pc_next     = pc_reg;
    offset_next = offset_reg;
    total_next  = total_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          list_next  = IR[15:0];
          rn_next    = IR[19:16];
          load_next  = IR[20];
          up_next    = IR[23];
          // A load that refills Rn itself must not be overwritten by the writeback.
          wb_next    = IR[21] & ~(IR[20] & IR[IR[19:16]]);
          pc_next    = IR[20] & IR[15];
          total_next = n_bytes;
          case ({IR[24], IR[23]})
            2'b01:   offset_next = '0;
            2'b11:   offset_next = STEP;
            2'b00:   offset_next = STEP - n_bytes;
            default: offset_next = 32'd0 - n_bytes;
          endcase
          state_next = (IR[15:0] == 16'd0) ? DONE : XFER;
        end
      end
      XFER: begin
        if (mem_ready) begin
          list_next   = list_reg & (list_reg - 16'd1);
          offset_next = offset_reg + STEP;
          if (last_beat) begin
            state_next = wb_reg ? WB : DONE;
          end
        end
      end
      WB:      state_next = DONE;
      default: begin
        state_next = IDLE;
        list_next  = '0;
      end
    endcase
  end

  always_comb begin
    busy        = 1'b0;
    LSM_RD      = '0;
    LSM_RD_MUX  = 1'b0;
    LATCH_REG   = 1'b0;
    REG_GATE_C  = 1'b0;
    MEM_RD      = 1'b0;
    MEM_WR      = 1'b0;
    ADDR_OFFSET = '0;
    WB_EN       = 1'b0;
    WB_OFFSET   = '0;
    done        = 1'b0;
`ifdef LSM_PC_LOAD_EN
    pc_loaded   = 1'b0;
`endif
    case (state_reg)
      XFER: begin
        busy        = 1'b1;
        LSM_RD      = low_idx;
        LSM_RD_MUX  = 1'b1;
        MEM_RD      = load_reg;
        LATCH_REG   = load_reg & mem_ready;
        MEM_WR      = ~load_reg;
        REG_GATE_C  = ~load_reg;
        ADDR_OFFSET = offset_reg;
      end
      WB: begin
        busy       = 1'b1;
        LSM_RD     = rn_reg;
        LSM_RD_MUX = 1'b1;
        LATCH_REG  = 1'b1;
        WB_EN      = 1'b1;
        WB_OFFSET  = up_reg ? total_reg : (32'd0 - total_reg);
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
`ifdef LSM_PC_LOAD_EN
        pc_loaded = pc_reg;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsm_sequencer.sv
// Self-checking bench for lsm_sequencer: vector table, directed corner sequences, randomized model runs.
module tb_lsm_sequencer;

  localparam int  WBYTES = 4;
  localparam logic HI = 1'b1;
  localparam logic LO = 1'b0;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] IR;
  logic        mem_ready;
  logic        busy;
  logic [3:0]  LSM_RD;
  logic        LSM_RD_MUX;
  logic        LATCH_REG;
  logic        REG_GATE_C;
  logic        MEM_RD;
  logic        MEM_WR;
  logic [31:0] ADDR_OFFSET;
  logic        WB_EN;
  logic [31:0] WB_OFFSET;
  logic        done;
`ifdef LSM_PC_LOAD_EN
  logic        pc_loaded;
`endif

  int total = 0;
  int bad   = 0;

  lsm_sequencer #(.WORD_BYTES(WBYTES)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .IR          (IR),
    .mem_ready   (mem_ready),
    .busy        (busy),
    .LSM_RD      (LSM_RD),
    .LSM_RD_MUX  (LSM_RD_MUX),
    .LATCH_REG   (LATCH_REG),
    .REG_GATE_C  (REG_GATE_C),
    .MEM_RD      (MEM_RD),
    .MEM_WR      (MEM_WR),
    .ADDR_OFFSET (ADDR_OFFSET),
    .WB_EN       (WB_EN),
    .WB_OFFSET   (WB_OFFSET),
`ifdef LSM_PC_LOAD_EN
    .pc_loaded   (pc_loaded),
`endif
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir;
    int          beats;
    logic [31:0] first;
    logic        wb;
    logic [31:0] wboff;
    int          lat;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [75:0] pack_outs();
    return {busy, LSM_RD, LSM_RD_MUX, LATCH_REG, REG_GATE_C, MEM_RD, MEM_WR,
            ADDR_OFFSET, WB_EN, WB_OFFSET, done};
  endfunction

  function automatic logic [75:0] exp_outs(input logic b, input logic [3:0] rd, input logic mux,
                                           input logic latch, input logic gate, input logic mrd,
                                           input logic mwr, input logic [31:0] addr,
                                           input logic wben, input logic [31:0] wboff,
                                           input logic dn);
    return {b, rd, mux, latch, gate, mrd, mwr, addr, wben, wboff, dn};
  endfunction

  // Present start/IR at a falling edge; the following rising edge accepts it.
  task automatic accept(input logic [31:0] ir);
    @(negedge clk);
    IR = ir;
    start = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    IR = $urandom;
  endtask

  task automatic step(input logic mr);
    @(negedge clk);
    mem_ready = mr;
    #1;
  endtask

  // Reference: builds the expected per-cycle trace from the ordered register list and mode arithmetic.
  task automatic model_txn(input logic [31:0] ir, input int stall_pct, input int id);
    int          regs[$];
    int          n, k, cyc;
    logic        L, W, U, P, mr, do_wb;
    logic [3:0]  rn;
    logic [31:0] first, addr, nb;
    for (int i = 0; i < 16; i++) if (ir[i]) regs.push_back(i);
    n  = regs.size();
    L  = ir[20];
    W  = ir[21];
    U  = ir[23];
    P  = ir[24];
    rn = ir[19:16];
    nb = WBYTES * n;
    if (!P && U)      first = 32'd0;
    else if (P && U)  first = WBYTES;
    else if (!P)      first = 0 - WBYTES * (n - 1);
    else              first = 0 - nb;
    do_wb = W && (n > 0) && !(L && ir[rn]);

    @(negedge clk);
    start = 1'b0;
    #1;
    check("idle_pre", pack_outs(), 76'h0);
    IR = ir;
    start = 1'b1;
    mem_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    k = 0;
    cyc = 0;
    while (k < n && cyc < 2000) begin
      @(negedge clk);
      mr = ($urandom_range(0, 99) >= stall_pct);
      mem_ready = mr;
      start = 1'($urandom_range(0, 1));
      IR = $urandom;
      #1;
      addr = first + WBYTES * k;
      check("xfer", pack_outs(),
            exp_outs(HI, 4'(regs[k]), HI, L & mr, !L, L, !L, addr, LO, 32'd0, LO));
      if (mr) k++;
      cyc++;
    end
    if (k < n) check("xfer_budget", 128'(k), 128'(n));
    if (do_wb) begin
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1));
      #1;
      check("wb", pack_outs(),
            exp_outs(HI, rn, HI, HI, LO, LO, LO, 32'd0, HI, U ? nb : (0 - nb), LO));
    end
    @(negedge clk);
    mem_ready = 1'($urandom_range(0, 1));
    start = 1'($urandom_range(0, 1));
    #1;
    check("done", pack_outs(), exp_outs(HI, 4'd0, LO, LO, LO, LO, LO, 32'd0, LO, 32'd0, HI));
`ifdef LSM_PC_LOAD_EN
    check("pc_loaded", 128'(pc_loaded), 128'(L & ir[15]));
`endif
    @(negedge clk);
    start = 1'b0;
    #1;
    check("idle_post", pack_outs(), 76'h0);
    $display("rand txn %0d ir=%08h n=%0d wb=%0d cycles=%0d", id, ir, n, do_wb, cyc);
  endtask

  initial begin
    int beats, lat;
    logic [31:0] first_seen, wbo;
    logic wbs, got_first;
    logic [31:0] rir;

    vecs[0] = '{32'h003100F0, 4,  32'hFFFFFFF4, 1'b1, 32'hFFFFFFF0, 6};
    vecs[1] = '{32'h00B20004, 1,  32'h00000000, 1'b0, 32'h00000000, 2};
    vecs[2] = '{32'h00A20004, 1,  32'h00000000, 1'b1, 32'h00000004, 3};
    vecs[3] = '{32'h012DFFFF, 16, 32'hFFFFFFC0, 1'b1, 32'hFFFFFFC0, 18};
    vecs[4] = '{32'h00A00000, 0,  32'h00000000, 1'b0, 32'h00000000, 1};
    vecs[5] = '{32'h01B58000, 1,  32'h00000004, 1'b1, 32'h00000004, 3};
    vecs[6] = '{32'h00040001, 1,  32'h00000000, 1'b0, 32'h00000000, 2};

    rst = 1'b1;
    start = 1'b0;
    IR = '0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset", pack_outs(), 76'h0);
    rst = 1'b0;

    // LDMIA r3, {r0,r2}
    accept(32'h00930005);
    step(HI); check("ldmia_b1", pack_outs(), exp_outs(HI, 4'd0, HI, HI, LO, HI, LO, 32'd0, LO, 32'd0, LO));
    step(HI); check("ldmia_b2", pack_outs(), exp_outs(HI, 4'd2, HI, HI, LO, HI, LO, 32'd4, LO, 32'd0, LO));
    step(HI); check("ldmia_done", pack_outs(), exp_outs(HI, 4'd0, LO, LO, LO, LO, LO, 32'd0, LO, 32'd0, HI));
    step(HI); check("ldmia_idle", pack_outs(), 76'h0);
    $display("seq ldmia list=0005");

    // STMDB r13!, {r4,r14}
    accept(32'h012D4010);
    step(HI); check("stmdb_b1", pack_outs(), exp_outs(HI, 4'd4, HI, LO, HI, LO, HI, 32'hFFFFFFF8, LO, 32'd0, LO));
    step(HI); check("stmdb_b2", pack_outs(), exp_outs(HI, 4'd14, HI, LO, HI, LO, HI, 32'hFFFFFFFC, LO, 32'd0, LO));
    step(HI); check("stmdb_wb", pack_outs(), exp_outs(HI, 4'd13, HI, HI, LO, LO, LO, 32'd0, HI, 32'hFFFFFFF8, LO));
    step(HI); check("stmdb_done", pack_outs(), exp_outs(HI, 4'd0, LO, LO, LO, LO, LO, 32'd0, LO, 32'd0, HI));
    step(HI); check("stmdb_idle", pack_outs(), 76'h0);
    $display("seq stmdb list=4010");

    // LDMIB with three wait cycles
    accept(32'h01900002);
    for (int i = 0; i < 3; i++) begin
      step(LO);
      check("ldmib_stall", pack_outs(), exp_outs(HI, 4'd1, HI, LO, LO, HI, LO, 32'd4, LO, 32'd0, LO));
    end
    step(HI); check("ldmib_beat", pack_outs(), exp_outs(HI, 4'd1, HI, HI, LO, HI, LO, 32'd4, LO, 32'd0, LO));
    step(HI); check("ldmib_done", pack_outs(), exp_outs(HI, 4'd0, LO, LO, LO, LO, LO, 32'd0, LO, 32'd0, HI));
    $display("seq ldmib stalled");

    // Empty list, second start while busy
    accept(32'h00900000);
    @(negedge clk);
    start = 1'b1;
    #1;
    check("empty_done", pack_outs(), exp_outs(HI, 4'd0, LO, LO, LO, LO, LO, 32'd0, LO, 32'd0, HI));
    @(negedge clk);
    start = 1'b0;
    #1;
    check("empty_idle1", pack_outs(), 76'h0);
    step(HI); check("empty_idle2", pack_outs(), 76'h0);
    $display("seq empty list");

    // Reset during second beat of a 4-register load
    accept(32'h0090000F);
    step(HI); check("rst_b1", pack_outs(), exp_outs(HI, 4'd0, HI, HI, LO, HI, LO, 32'd0, LO, 32'd0, LO));
    @(negedge clk);
    mem_ready = 1'b1;
    rst = 1'b1;
    #1;
    check("rst_b2", pack_outs(), exp_outs(HI, 4'd1, HI, HI, LO, HI, LO, 32'd4, LO, 32'd0, LO));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_after", pack_outs(), 76'h0);
    step(HI); check("rst_idle", pack_outs(), 76'h0);
    $display("seq reset mid-transfer");

`ifdef LSM_PC_LOAD_EN
    accept(32'h00908001);
    step(HI); check("pc_b1", 128'(pc_loaded), 128'(0));
    step(HI); check("pc_b2", 128'(pc_loaded), 128'(0));
    step(HI); check("pc_done", 128'({done, pc_loaded}), 128'(2'b11));
    step(HI); check("pc_idle", 128'(pc_loaded), 128'(0));
    $display("seq pc load");
`endif

    for (int v = 0; v < 7; v++) begin
      accept(vecs[v].ir);
      beats = 0; lat = 0; first_seen = '0; wbo = '0; wbs = 1'b0; got_first = 1'b0;
      for (int c = 1; c <= 40 && lat == 0; c++) begin
        step(HI);
        if (MEM_RD | MEM_WR) begin
          if (!got_first) first_seen = ADDR_OFFSET;
          got_first = 1'b1;
          beats++;
        end
        if (WB_EN) begin
          wbs = 1'b1;
          wbo = WB_OFFSET;
        end
        if (done) lat = c;
      end
      check("vec_beats", 128'(beats), 128'(vecs[v].beats));
      check("vec_first", 128'(first_seen), 128'(vecs[v].first));
      check("vec_wb", 128'(wbs), 128'(vecs[v].wb));
      check("vec_wboff", 128'(wbo), 128'(vecs[v].wboff));
      check("vec_lat", 128'(lat), 128'(vecs[v].lat));
      $display("vec %0d ir=%08h beats=%0d lat=%0d", v, vecs[v].ir, beats, lat);
    end

    for (int t = 0; t < 40; t++) begin
      rir = $urandom;
      rir[15:0] = 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 5) == 0) rir[15:0] = 16'h0;
      model_txn(rir, $urandom_range(0, 60), t);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
